// File: rtl/morsecode_pkg.sv
// Shared definitions for the Morse code datapath: pattern widths,
// letter codes used by the encoder, and the transmitter state encoding.
package morsecode_pkg;

  localparam int MC_LEN_W = 4;
  localparam int MC_PAT_W = 11;

  // Letter selection codes shared with morsecode_encoder
  typedef enum logic [2:0] {
    LETTER_A = 3'b000,
    LETTER_B = 3'b001,
    LETTER_C = 3'b010,
    LETTER_D = 3'b011,
    LETTER_E = 3'b100,
    LETTER_F = 3'b101,
    LETTER_G = 3'b110,
    LETTER_H = 3'b111
  } letter_e;

  // Transmitter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  // Lengths above the pattern width are treated as a full-width pattern
  function automatic logic [MC_LEN_W-1:0] clamp_len(input logic [MC_LEN_W-1:0] len);
    logic [MC_LEN_W-1:0] max_len;
    max_len = MC_LEN_W'(MC_PAT_W);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/morsecode_tick_gen.sv
// Morse unit timer: counts TICK_DIV clock cycles and pulses tick on the
// cycle where the count wraps back to zero.
module morsecode_tick_gen
  import morsecode_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the end of a unit
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable) begin
      if (tick_cnt_q == LAST_CNT) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/morsecode_transmitter.sv
// Plays one encoded Morse letter LSB-first on led_out, one unit per bit,
// followed by GAP_UNITS dark units, then pulses done for one cycle.
module morsecode_transmitter
  import morsecode_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int GAP_UNITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MC_LEN_W-1:0] morsecode_length,
  input  logic [MC_PAT_W-1:0] morsecode_shiftreg,
  output logic                led_out,
  output logic                busy,
  output logic                done
);

  localparam int GAP_W = (GAP_UNITS < 1) ? 1 : $clog2(GAP_UNITS + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_UNITS);

  tx_state_e           state_q, state_d;
  logic [MC_PAT_W-1:0] shreg_q, shreg_d;
  logic [MC_LEN_W-1:0] bits_left_q, bits_left_d;
  logic [GAP_W-1:0]    gap_left_q, gap_left_d;
  logic                done_q, done_d;
  logic                tick;
  logic [MC_LEN_W-1:0] clamped_len;

  assign clamped_len = clamp_len(morsecode_length);

  // Unit timer runs only while a letter or its gap is in flight
  morsecode_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == IDLE),
    .enable(state_q != IDLE),
    .tick  (tick)
  );

  // Next-state logic: capture on start, shift per unit, count out the gap
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    gap_left_d  = gap_left_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d     = morsecode_shiftreg;
          bits_left_d = clamped_len;
          if (clamped_len != '0) begin
            state_d = SEND;
          end else if (GAP_UNITS != 0) begin
            state_d    = GAP;
            gap_left_d = GAP_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tick) begin
          shreg_d     = shreg_q >> 1;
          bits_left_d = bits_left_q - 1'b1;
          if (bits_left_q == MC_LEN_W'(1)) begin
            if (GAP_UNITS != 0) begin
              state_d    = GAP;
              gap_left_d = GAP_LOAD;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          gap_left_d = gap_left_q - 1'b1;
          if (gap_left_q == GAP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      gap_left_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      gap_left_q  <= gap_left_d;
      done_q      <= done_d;
    end
  end

  assign led_out = (state_q == SEND) && shreg_q[0];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_morsecode_transmitter.sv
// Scoreboard bench for morsecode_transmitter: every accepted letter pushes its
// expected per-cycle {busy, led_out, done} trace; a monitor pops and compares.
module tb_morsecode_transmitter;
  import morsecode_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int GAP_UNITS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  morsecode_length = '0;
  logic [10:0] morsecode_shiftreg = '0;
  logic        led_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_q[$];

  morsecode_transmitter #(
    .TICK_DIV (TICK_DIV),
    .GAP_UNITS(GAP_UNITS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .morsecode_length  (morsecode_length),
    .morsecode_shiftreg(morsecode_shiftreg),
    .led_out           (led_out),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Compare one observed {busy, led_out, done} vector against its expectation
  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: busy/led/done got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  // Reference model: a letter is L bits of TICK_DIV cycles each, then a dark
  // gap of GAP_UNITS units, then one idle cycle carrying the done pulse
  task automatic pushLetter(input logic [3:0] len, input logic [10:0] pat);
    int l;
    l = (int'(len) > 11) ? 11 : int'(len);
    for (int i = 0; i < l; i++)
      for (int t = 0; t < TICK_DIV; t++)
        exp_q.push_back({1'b1, pat[i], 1'b0});
    for (int t = 0; t < GAP_UNITS * TICK_DIV; t++)
      exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
  endtask

  // Request a letter (start may be raised while the DUT is still busy), wait
  // until the model says the DUT is idle, record the expectation, then either
  // keep start high for a back-to-back letter or scramble inputs mid-letter
  task automatic applyStimulus(input logic [3:0] len, input logic [10:0] pat, input bit hold);
    int n;
    morsecode_length   = len;
    morsecode_shiftreg = pat;
    start              = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_wait at %0t: %0d entries pending, expected 0", $time, exp_q.size());
      exp_q.delete();
    end
    pushLetter(len, pat);
    @(negedge clk);
    #1;
    if (!hold) begin
      repeat (6) begin
        morsecode_length   = 4'($urandom_range(15, 0));
        morsecode_shiftreg = 11'($urandom);
        start              = 1'($urandom_range(1, 0));
        @(negedge clk);
        #1;
      end
      start = 1'b0;
    end
  endtask

  // Monitor: one comparison per clock cycle while out of reset
  always @(negedge clk) begin
    logic [2:0] expv;
    if (rst_n) begin
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
      checkOutput("trace", {busy, led_out, done}, expv);
    end
  end

  // Global time limit so the bench can never hang
  initial begin
    #500_000;
    $display("[TB] FAIL watchdog at %0t: simulation did not finish, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    #1;
    checkOutput("reset_state", {busy, led_out, done}, 3'b000);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Letter A, then letter E
    applyStimulus(4'd5, 11'b00000011101, 1'b0);
    applyStimulus(4'd1, 11'b00000000001, 1'b0);

    // C then G with start held high across the boundary
    applyStimulus(4'd11, 11'b10111010111, 1'b1);
    applyStimulus(4'd9, 11'b00101110111, 1'b0);

    // Length clamp and zero length
    applyStimulus(4'd15, 11'b11011001101, 1'b0);
    applyStimulus(4'd0, 11'b11111111111, 1'b0);

    // Asynchronous reset in the middle of a lit bit of letter A
    applyStimulus(4'd5, 11'b00000011101, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_lit", {busy, led_out, done}, 3'b110);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {busy, led_out, done}, 3'b000);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("held_reset", {busy, led_out, done}, 3'b000);
    rst_n = 1'b1;

    // Replay after reset, then random letters
    applyStimulus(4'd5, 11'b00000011101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'($urandom_range(15, 0)), 11'($urandom), bit'($urandom_range(1, 0)));
    end

    // Drain the last letter and observe a few idle cycles
    start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain at %0t: %0d entries pending, expected 0", $time, exp_q.size());
    end
    repeat (4) @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
